des_job_dispatcher: RTL and testbench

DES_JOB_DISPATCHER -- requirements
Module: des_job_dispatcher

---
 rtl/des_job_dispatcher.sv | 176 +++++++++++++++++
 tb/tb_des_job_dispatcher.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/des_job_dispatcher.sv
// Sequences DES search jobs (READ_REGION, START, RESTART) and buffers results in a small FIFO.
// Optional WAIT_DONE watchdog is compiled in when DES_DISPATCH_TIMEOUT_EN is defined.
module des_job_dispatcher #(
    parameter int          RES_DEPTH      = 4,
    parameter logic [31:0] TIMEOUT_CYCLES = 32'hFFFF_FFFF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] job_region,
    input  logic        job_valid,
    output logic        job_ready,
    output logic [1:0]  cmd,
    output logic        cmd_valid,
    input  logic        cmd_read,
    output logic [15:0] region,
    input  logic        des_done,
    input  logic [63:0] des_counter,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [15:0] res_region,
    output logic [63:0] res_counter,
    output logic        res_timeout,
    output logic        busy,
    output logic [31:0] jobs_done
);
    localparam int PTR_W = (RES_DEPTH > 1) ? $clog2(RES_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [1:0] CMD_READ_REGION = 2'd0;
    localparam logic [1:0] CMD_START       = 2'd1;
    localparam logic [1:0] CMD_RESTART     = 2'd3;

    if (RES_DEPTH < 2 || RES_DEPTH > 16 || (RES_DEPTH & (RES_DEPTH - 1)) != 0 ||
        TIMEOUT_CYCLES == 32'd0) begin : g_bad_params
        $error("des_job_dispatcher: illegal parameter value");
    end

    typedef enum logic [2:0] {
        S_IDLE, S_SEND_REGION, S_SEND_START, S_WAIT_DONE, S_CAPTURE, S_SEND_RESTART
    } state_t;

    state_t           r_state, w_next_state;
    logic             r_cmd_valid;
    logic [1:0]       r_cmd;
    logic [15:0]      r_region;
    logic [15:0]      r_mem_region  [RES_DEPTH];
    logic [63:0]      r_mem_counter [RES_DEPTH];
    logic [PTR_W-1:0] r_wr_ptr, r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic [31:0]      r_jobs_done;
    logic             w_cmd_hs, w_fifo_space, w_push, w_pop, w_accept, w_timeout_hit;
    logic             w_next_send;
    logic [1:0]       w_next_cmd;

    // cmd_valid only rises inside SEND_* states, so cmd_read is ignored elsewhere
    assign w_cmd_hs     = r_cmd_valid && cmd_read;
    assign w_fifo_space = (r_count < CNT_W'(RES_DEPTH));
    assign res_valid    = (r_count != '0);
    assign w_pop        = res_valid && res_ready;

`ifdef DES_DISPATCH_TIMEOUT_EN
    logic [31:0] r_wd_cnt;
    logic        r_timed_out;
    logic        r_mem_timeout [RES_DEPTH];

    assign w_timeout_hit = (r_state == S_WAIT_DONE) && (r_wd_cnt == TIMEOUT_CYCLES - 32'd1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wd_cnt    <= '0;
            r_timed_out <= 1'b0;
        end else begin
            r_wd_cnt <= (r_state == S_WAIT_DONE) ? r_wd_cnt + 32'd1 : '0;
            // a real done in the expiry cycle wins over the watchdog
            if (w_accept)
                r_timed_out <= 1'b0;
            else if (w_timeout_hit && !des_done)
                r_timed_out <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push)
            r_mem_timeout[r_wr_ptr] <= r_timed_out;
    end

    assign res_timeout = res_valid && r_mem_timeout[r_rd_ptr];
`else
    assign w_timeout_hit = 1'b0;
    assign res_timeout   = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= S_IDLE;
        else
            r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            S_IDLE:         if (job_valid)                  w_next_state = S_SEND_REGION;
            S_SEND_REGION:  if (w_cmd_hs)                   w_next_state = S_SEND_START;
            S_SEND_START:   if (w_cmd_hs)                   w_next_state = S_WAIT_DONE;
            S_WAIT_DONE:    if (des_done || w_timeout_hit)  w_next_state = S_CAPTURE;
            S_CAPTURE:      if (w_fifo_space)               w_next_state = S_SEND_RESTART;
            S_SEND_RESTART: if (w_cmd_hs)                   w_next_state = S_IDLE;
            default:                                        w_next_state = S_IDLE;
        endcase
    end

    always_comb begin
        job_ready   = (r_state == S_IDLE);
        busy        = (r_state != S_IDLE);
        w_accept    = (r_state == S_IDLE) && job_valid;
        w_push      = (r_state == S_CAPTURE) && w_fifo_space;
        w_next_send = 1'b0;
        w_next_cmd  = CMD_READ_REGION;
        unique case (w_next_state)
            S_SEND_REGION:  begin w_next_send = 1'b1; w_next_cmd = CMD_READ_REGION; end
            S_SEND_START:   begin w_next_send = 1'b1; w_next_cmd = CMD_START;       end
            S_SEND_RESTART: begin w_next_send = 1'b1; w_next_cmd = CMD_RESTART;     end
            default:        begin w_next_send = 1'b0; w_next_cmd = CMD_READ_REGION; end
        endcase
    end

    // A handshake always drops cmd_valid for one cycle before the next command is offered
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cmd_valid <= 1'b0;
            r_cmd       <= CMD_READ_REGION;
            r_region    <= '0;
        end else begin
            r_cmd_valid <= w_next_send && !w_cmd_hs;
            if (w_next_send && !w_cmd_hs)
                r_cmd <= w_next_cmd;
            if (w_accept)
                r_region <= job_region;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_jobs_done <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr    <= r_wr_ptr + 1'b1;
                r_jobs_done <= r_jobs_done + 32'd1;
            end
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_push && !w_pop)
                r_count <= r_count + 1'b1;
            else if (!w_push && w_pop)
                r_count <= r_count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_region[r_wr_ptr]  <= r_region;
            r_mem_counter[r_wr_ptr] <= des_counter;
        end
    end

    assign cmd         = r_cmd;
    assign cmd_valid   = r_cmd_valid;
    assign region      = r_region;
    assign jobs_done   = r_jobs_done;
    assign res_region  = res_valid ? r_mem_region[r_rd_ptr]  : '0;
    assign res_counter = res_valid ? r_mem_counter[r_rd_ptr] : '0;

endmodule

// File: tb/tb_des_job_dispatcher.sv
// Scoreboard bench for des_job_dispatcher: a DES-block model answers commands, monitors check
// every command handshake and every popped result against queues filled when jobs are issued.
module tb_des_job_dispatcher;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] job_region;
    logic        job_valid;
    logic        job_ready;
    logic [1:0]  cmd;
    logic        cmd_valid;
    logic        cmd_read;
    logic [15:0] region;
    logic        des_done;
    logic [63:0] des_counter;
    logic        res_valid;
    logic        res_ready;
    logic [15:0] res_region;
    logic [63:0] res_counter;
    logic        res_timeout;
    logic        busy;
    logic [31:0] jobs_done;

    des_job_dispatcher #(.RES_DEPTH(4), .TIMEOUT_CYCLES(32'd10)) dut (
        .clk(clk), .rst_n(rst_n),
        .job_region(job_region), .job_valid(job_valid), .job_ready(job_ready),
        .cmd(cmd), .cmd_valid(cmd_valid), .cmd_read(cmd_read), .region(region),
        .des_done(des_done), .des_counter(des_counter),
        .res_valid(res_valid), .res_ready(res_ready), .res_region(res_region),
        .res_counter(res_counter), .res_timeout(res_timeout),
        .busy(busy), .jobs_done(jobs_done)
    );

    always #5 clk = ~clk;

    typedef struct { logic [1:0] c; logic [15:0] r; } cmd_t;
    typedef struct { logic [15:0] r; logic [63:0] c; logic t; } res_t;

    cmd_t        exp_cmd_q[$];
    res_t        exp_res_q[$];
    logic [63:0] cnt_q[$];

    int n_chk = 0;
    int n_pass = 0;
    int rd_delay = 0;
    int done_delay = 0;
    int gen = 0;
    bit no_done = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic fail(input string name);
        n_chk++;
        $display("FAIL %s: got event-missing expected event-present", name);
    endtask

    // DES search block model
    initial begin
        int          g;
        logic [1:0]  c;
        logic [63:0] nc;
        cmd_read = 1'b0; des_done = 1'b0; des_counter = '0;
        forever begin
            @(negedge clk);
            cmd_read = 1'b0;
            des_done = 1'b0;
            if (rst_n && cmd_valid) begin
                g = gen;
                c = cmd;
                for (int i = 0; i < rd_delay; i++) @(negedge clk);
                if (g != gen) continue;
                cmd_read = 1'b1;
                @(negedge clk);
                cmd_read = 1'b0;
                if (c == 2'd1) begin
                    nc = (cnt_q.size() > 0) ? cnt_q.pop_front() : 64'd0;
                    for (int i = 0; i < done_delay; i++) begin
                        @(negedge clk);
                        if (g != gen) break;
                    end
                    if (g == gen) begin
                        des_counter = nc;
                        if (!no_done) des_done = 1'b1;
                    end
                end
            end
        end
    end

    // command monitor
    initial begin
        cmd_t e;
        forever begin
            @(negedge clk); #1;
            if (rst_n && cmd_valid && cmd_read) begin
                if (exp_cmd_q.size() == 0) fail("cmd_unexpected");
                else begin
                    e = exp_cmd_q.pop_front();
                    check("cmd_code", cmd, e.c);
                    check("cmd_region", region, e.r);
                end
            end
        end
    end

    // result monitor
    initial begin
        res_t e;
        forever begin
            @(negedge clk); #1;
            if (rst_n && res_valid && res_ready) begin
                if (exp_res_q.size() == 0) fail("res_unexpected");
                else begin
                    e = exp_res_q.pop_front();
                    check("res_region", res_region, e.r);
                    check("res_counter", res_counter, e.c);
                    check("res_timeout", res_timeout, e.t);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "bench timeout");
    end

    task automatic submit(input logic [15:0] r, input logic [63:0] c, input logic to, input int hold);
        int n = 0;
        while (!job_ready && n < 300) begin @(negedge clk); n++; end
        if (!job_ready) begin fail("job_ready_wait"); return; end
        exp_cmd_q.push_back('{2'd0, r});
        exp_cmd_q.push_back('{2'd1, r});
        exp_cmd_q.push_back('{2'd3, r});
        exp_res_q.push_back('{r, c, to});
        cnt_q.push_back(c);
        job_region = r;
        job_valid  = 1'b1;
        @(negedge clk);
        check("accept_to_cmd_valid", cmd_valid, 1);
        check("region_latched", region, r);
        for (int i = 0; i < hold; i++) begin
            job_region = ~r;
            @(negedge clk);
            check("held_region", region, r);
            check("held_job_ready", job_ready, 0);
        end
        job_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while (busy && n < 500) begin @(negedge clk); n++; end
        if (busy) fail("wait_idle_timeout");
    endtask

    initial begin
        int n;
        rst_n = 1'b0; job_valid = 1'b0; job_region = '0; res_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_cmd_valid", cmd_valid, 0);
        check("rst_cmd", cmd, 0);
        check("rst_region", region, 0);
        check("rst_res_valid", res_valid, 0);
        check("rst_res_region", res_region, 0);
        check("rst_res_counter", res_counter, 0);
        check("rst_res_timeout", res_timeout, 0);
        check("rst_jobs_done", jobs_done, 0);
        check("rst_busy", busy, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_job_ready", job_ready, 1);

        // single job, immediate cmd_read
        submit(16'h0005, 64'h1234, 1'b0, 0);
        wait_idle();
        check("single_jobs_done", jobs_done, 1);

        // cmd_read delayed 5 cycles: command must hold steady
        rd_delay = 5;
        submit(16'hA5A5, 64'hDEAD_BEEF_0000_0001, 1'b0, 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("delayed_cmd_valid", cmd_valid, 1);
            check("delayed_cmd", cmd, 0);
        end
        wait_idle();
        rd_delay = 0;
        check("delayed_jobs_done", jobs_done, 2);

        // job_valid held while busy with a changing region
        done_delay = 10;
        submit(16'h1111, 64'h0000_0000_0000_0011, 1'b0, 6);
        wait_idle();
        done_delay = 0;
        check("held_jobs_done", jobs_done, 3);

        // FIFO full: 5th result waits in CAPTURE, no RESTART
        res_ready = 1'b0;
        for (int i = 0; i < 5; i++)
            submit(16'h0020 + 16'(i), 64'h100 + 64'(i), 1'b0, 0);
        repeat (10) @(negedge clk);
        check("full_jobs_done", jobs_done, 7);
        check("full_busy", busy, 1);
        check("full_res_valid", res_valid, 1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("full_no_restart", cmd_valid, 0);
        end
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        check("full_push_not_same_cycle", jobs_done, 7);
        @(negedge clk);
        check("full_push_after_pop", jobs_done, 8);
        res_ready = 1'b1;
        wait_idle();
        repeat (6) @(negedge clk);
        check("full_drained", res_valid, 0);

        // simultaneous push and pop with two entries buffered
        res_ready = 1'b0;
        submit(16'h0030, 64'h3000, 1'b0, 0);
        wait_idle();
        submit(16'h0031, 64'h3100, 1'b0, 0);
        wait_idle();
        submit(16'h0032, 64'h3200, 1'b0, 0);
        n = 0;
        do begin @(posedge clk); #1; n++; end while (!des_done && n < 100);
        if (!des_done) fail("des_done_wait");
        @(negedge clk);
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b1;
        check("pp_jobs_done", jobs_done, 11);
        check("pp_res_valid", res_valid, 1);
        @(negedge clk);
        check("pp_count_after_one_pop", res_valid, 1);
        @(negedge clk);
        res_ready = 1'b0;
        check("pp_count_after_two_pops", res_valid, 0);
        wait_idle();

        // reset while waiting for des_done with one result buffered
        submit(16'h0040, 64'h4040, 1'b0, 0);
        wait_idle();
        done_delay = 30;
        submit(16'h0041, 64'h4141, 1'b0, 0);
        repeat (6) @(negedge clk);
        check("pre_rst_busy", busy, 1);
        check("pre_rst_res_valid", res_valid, 1);
        #2;
        rst_n = 1'b0;
        gen++;
        #1;
        check("arst_cmd_valid", cmd_valid, 0);
        check("arst_res_valid", res_valid, 0);
        check("arst_busy", busy, 0);
        check("arst_jobs_done", jobs_done, 0);
        check("arst_region", region, 0);
        exp_cmd_q.delete();
        exp_res_q.delete();
        cnt_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        res_ready = 1'b1;
        done_delay = 0;
        submit(16'h0050, 64'h5050, 1'b0, 0);
        wait_idle();
        check("post_rst_jobs_done", jobs_done, 1);

`ifdef DES_DISPATCH_TIMEOUT_EN
        no_done = 1'b1;
        submit(16'h0060, 64'h6060, 1'b1, 0);
        n = 0;
        while (jobs_done == 32'd1 && n < 100) begin @(negedge clk); n++; end
        check("wd_jobs_done", jobs_done, 2);
        check("wd_cycles", n, 14);
        wait_idle();
        no_done = 1'b0;
`endif

        repeat (5) @(negedge clk);
        check("cmd_queue_empty", exp_cmd_q.size(), 0);
        check("res_queue_empty", exp_res_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
